// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: detects load-use and multiply/divide hazards that bypassing
// cannot resolve, freezes IF/ID and bubbles ID/EX, tracks the in-flight MD op
// and keeps a saturating stall-cycle counter.
module hazard_stall_unit #(
  parameter int unsigned MD_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_valid,
  input  logic        ID_flush,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_use_rs,
  input  logic        ID_use_rt,
  input  logic        ID_is_md,
  input  logic [4:0]  ID_WR,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_WR_out,
  output logic        stall,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        ID_EX_Bubble,
  output logic        md_busy,
  output logic        md_done,
  output logic [4:0]  md_WR_out,
  output logic [15:0] stall_cnt
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned SCNT_W = 16;

  logic [CNT_W-1:0]  r_md_cnt;
  logic [REG_W-1:0]  r_md_dest;
  logic [SCNT_W-1:0] r_stall_cnt;

  logic w_rd_rs;
  logic w_rd_rt;
  logic w_load_use;
  logic w_md_data;
  logic w_md_struct;
  logic w_stall;
  logic w_issue;

  // Hazard detection; a flushed instruction or an asserted reset never stalls.
  always_comb begin
    w_rd_rs     = ID_valid & ID_use_rs;
    w_rd_rt     = ID_valid & ID_use_rt;
    w_load_use  = EX_MemRead & (EX_WR_out != '0) &
                  ((w_rd_rs & (EX_WR_out == ID_Rs)) | (w_rd_rt & (EX_WR_out == ID_Rt)));
    w_md_data   = (r_md_cnt != '0) & (r_md_dest != '0) &
                  ((w_rd_rs & (r_md_dest == ID_Rs)) | (w_rd_rt & (r_md_dest == ID_Rt)));
    // md_cnt == 1 is the writeback cycle, so a new MD may issue then.
    w_md_struct = ID_valid & ID_is_md & (r_md_cnt > CNT_W'(1));
    w_stall     = rst & ~ID_flush & (w_load_use | w_md_data | w_md_struct);
    w_issue     = ID_valid & ID_is_md & ~ID_flush & ~w_stall;
  end

  // MD countdown/destination tracking; a new issue overrides the decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_md_cnt  <= '0;
      r_md_dest <= '0;
    end else if (w_issue) begin
      r_md_cnt  <= CNT_W'(MD_LAT);
      r_md_dest <= ID_WR;
    end else if (r_md_cnt != '0) begin
      r_md_cnt  <= r_md_cnt - CNT_W'(1);
    end
  end

  // Saturating count of stalled cycles for performance debug.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + SCNT_W'(1);
    end
  end

  // Pipeline control and status outputs.
  always_comb begin
    stall        = w_stall;
    PC_Write     = ~w_stall;
    IF_ID_Write  = ~w_stall;
    ID_EX_Bubble = w_stall;
    md_busy      = (r_md_cnt != '0);
    md_done      = (r_md_cnt == CNT_W'(1));
    md_WR_out    = r_md_dest;
    stall_cnt    = r_stall_cnt;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall-side companion to the forwarding unit in the 5-stage MIPS pipeline. The forwarding unit resolves hazards it can bypass. This block detects the hazards bypassing cannot cover and freezes IF/ID while inserting a bubble into ID/EX. The covered hazards are a load-use dependence on the EX-stage load, and dependences or structural conflicts with the multi-cycle multiply/divide unit, whose pending destination and countdown are tracked here. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- MD_LAT, 4: multiply/divide latency in cycles from issue edge to writeback cycle; legal range 2..15.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ID_valid  in  1  ID stage holds a real instruction.
- ID_flush  in  1  ID instruction is being squashed (taken branch/jump) this cycle.
- ID_Rs, ID_Rt  in  5 each  source registers of the ID instruction.
- ID_use_rs, ID_use_rt  in  1 each  ID instruction actually reads Rs / Rt.
- ID_is_md  in  1  ID instruction is a multiply/divide.
- ID_WR  in  5  destination register of the ID instruction.
- EX_MemRead  in  1  EX instruction is a load.
- EX_WR_out  in  5  destination of the EX instruction.
- stall  out  1  hazard detected; pipeline front end frozen.
- PC_Write  out  1  PC write enable; equals !stall.
- IF_ID_Write  out  1  IF/ID write enable; equals !stall.
- ID_EX_Bubble  out  1  zero ID/EX control fields; equals stall.
- md_busy  out  1  multiply/divide in flight (md_cnt != 0).
- md_done  out  1  multiply/divide writeback cycle.
- md_WR_out  out  5  destination of the in-flight multiply/divide.
- stall_cnt  out  16  saturating count of stalled cycles.

## Operation
- Registered state: md_cnt (4 bits), md_dest (5 bits), stall_cnt (16 bits).
- rd_rs = ID_valid & ID_use_rs; rd_rt = ID_valid & ID_use_rt.
- Load-use hazard: EX_MemRead & EX_WR_out != 0 & ((rd_rs & EX_WR_out == ID_Rs) | (rd_rt & EX_WR_out == ID_Rt)).
- MD data hazard: md_cnt != 0 & md_dest != 0 & ((rd_rs & md_dest == ID_Rs) | (rd_rt & md_dest == ID_Rt)).
- MD structural hazard: ID_valid & ID_is_md & md_cnt > 1.
- stall = rst & !ID_flush & (load-use | MD data | MD structural).
- A flushed instruction never stalls and never issues.
- Issue: ID_valid & ID_is_md & !ID_flush & !stall at a rising edge. The edge loads md_cnt = MD_LAT and md_dest = ID_WR.
- Otherwise, if md_cnt != 0, md_cnt decrements by 1 per edge.
- md_done = (md_cnt == 1). md_WR_out = md_dest. md_busy = (md_cnt != 0).
- Issue in the md_done cycle is legal, because the structural check uses md_cnt > 1. The reload takes priority over the decrement, and md_dest is replaced.
- stall_cnt increments on each edge where stall = 1 and holds at 16'hFFFF.

## Timing
- Reset (rst low, asynchronous) values:
  - md_cnt = 0, md_dest = 0, stall_cnt = 0.
  - stall = 0, ID_EX_Bubble = 0, PC_Write = 1, IF_ID_Write = 1.
  - md_busy = 0, md_done = 0, md_WR_out = 0.
- stall, PC_Write, IF_ID_Write and ID_EX_Bubble are combinational from the current inputs and state, with zero latency.
- Load-use stall lasts exactly 1 cycle. Next cycle the load is in MEM, EX_MemRead is 0 for the bubble, and forwarding covers the rest.
- MD issued at edge t:
  - md_busy is high in cycles t+1..t+MD_LAT.
  - md_done is high in cycle t+MD_LAT only.
  - A dependent ID instruction stalls through cycle t+MD_LAT and proceeds in cycle t+MD_LAT+1 (register file write-before-read).
- Second MD behind a first (issued at t): stalls while md_cnt > 1 and issues at the edge ending cycle t+MD_LAT, giving back-to-back md_done spacing of MD_LAT.
- Reset asserted mid-operation aborts the in-flight MD: md_done is never produced, and state clears immediately.
- Destination $0: never causes an MD data hazard. An MD with ID_WR = 0 still occupies the unit structurally.

## Test plan
- Reset: drive rst = 0 with EX_MemRead = 1 and a matching Rs -> stall = 0, PC_Write = 1, stall_cnt = 0. Release reset -> stall = 1 that cycle.
- Load-use: EX_MemRead = 1, EX_WR_out = 8, ID_Rs = 8, ID_use_rs = 1 -> stall = 1 for one cycle, stall_cnt 0->1. Same case with ID_use_rs = 0 -> no stall. Same case with EX_WR_out = 0 -> no stall.
- MD dependence (MD_LAT = 4): issue MD with ID_WR = 10 at edge t. Next ID reads Rt = 10 -> stall in cycles t+1..t+4, md_done only in t+4 with md_WR_out = 10, stall_cnt = 4.
- Back-to-back MD: second MD presented at t+1 -> stalled t+1..t+3, issues at edge ending t+4. md_done fires at t+4 and t+8, with md_dest switching at t+4.
- Flush priority: ID_flush = 1 during an MD structural hazard with ID_is_md = 1 -> stall = 0 and md_cnt does not reload.
- Saturation and reset mid-op: force a long stall until stall_cnt = 16'hFFFF -> it holds. Assert rst with md_cnt = 2 -> md_busy drops immediately and no md_done follows.
